fetch_queue: RTL and testbench

Parametrised instruction-fetch front end for the pipelined core. It replaces the single-register Fetch stage with a PC generator, a memory read handshake that honours wait-requests, and a DEPTH-entry prefetch FIFO. It sits between instruction memory and Decode. It absorbs memory stalls and Decode back-pressure, and supports a one-cycle redirect/flush for taken branches.

---
 rtl/fetch_queue.sv | 104 ++++++++++
 tb/tb_fetch_queue.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: PC generator, wait-request aware memory read
// handshake and a DEPTH-entry prefetch FIFO feeding Decode, with one-cycle redirect.
module fetch_queue #(
  parameter int                   WORD_SIZE = 16,
  parameter int                   DEPTH     = 4,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
  input  logic                         Clock,
  input  logic                         Reset,
  output logic [WORD_SIZE-1:0]         InstrAddr,
  output logic                         InstrRead,
  input  logic [WORD_SIZE-1:0]         InstrIn,
  input  logic                         InstrWaitreq,
  input  logic                         Redirect,
  input  logic [WORD_SIZE-1:0]         RedirectPC,
  output logic                         OutValid,
  output logic [WORD_SIZE-1:0]         OutInstr,
  output logic [WORD_SIZE-1:0]         OutPC,
  input  logic                         OutReady,
  output logic [$clog2(DEPTH+1)-1:0]   Count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WORD_SIZE-1:0] fetch_pc_q, fetch_pc_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]        count_q, count_d;

  logic [WORD_SIZE-1:0] pc_mem_q    [DEPTH];
  logic [WORD_SIZE-1:0] instr_mem_q [DEPTH];

  logic push;
  logic pop;

  // Request eligibility uses only registered occupancy, so a full queue never
  // accepts a fetch in the same cycle Decode frees a slot.
  always_comb begin
    InstrAddr = fetch_pc_q;
    InstrRead = !Reset && !Redirect && (count_q < FULL_COUNT);
    push      = InstrRead && !InstrWaitreq;
    OutValid  = (count_q != '0);
    pop       = OutValid && OutReady && !Redirect;
    OutInstr  = instr_mem_q[rd_ptr_q];
    OutPC     = pc_mem_q[rd_ptr_q];
    Count     = count_q;
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    if (Redirect) begin
      fetch_pc_d = RedirectPC;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (push) begin
        fetch_pc_d = fetch_pc_q + WORD_SIZE'(1);
        wr_ptr_d   = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      fetch_pc_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset; entries are only observed once count says they are valid.
  always_ff @(posedge Clock) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
      instr_mem_q[wr_ptr_q] <= InstrIn;
    end
  end

  no_overflow: assert property (@(posedge Clock) disable iff (Reset)
    !(push && (count_q == FULL_COUNT)));
  no_underflow: assert property (@(posedge Clock) disable iff (Reset)
    !(pop && (count_q == '0)));

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
module tb_fetch_queue;

  localparam int WS = 16;
  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [WS-1:0] RESET_PC = 16'h0010;
  localparam logic [WS-1:0] XOR_KEY = 16'hA5A5;

  logic          Clock;
  logic          Reset;
  logic [WS-1:0] InstrAddr;
  logic          InstrRead;
  logic [WS-1:0] InstrIn;
  logic          InstrWaitreq;
  logic          Redirect;
  logic [WS-1:0] RedirectPC;
  logic          OutValid;
  logic [WS-1:0] OutInstr;
  logic [WS-1:0] OutPC;
  logic          OutReady;
  logic [CW-1:0] Count;

  int checks;
  int failures;
  int cycle;

  // reference model: fetch address and the ordered list of queued fetch addresses
  logic [WS-1:0] model_pc;
  logic [WS-1:0] model_q [$];

  fetch_queue #(.WORD_SIZE(WS), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .Clock(Clock), .Reset(Reset),
    .InstrAddr(InstrAddr), .InstrRead(InstrRead), .InstrIn(InstrIn),
    .InstrWaitreq(InstrWaitreq), .Redirect(Redirect), .RedirectPC(RedirectPC),
    .OutValid(OutValid), .OutInstr(OutInstr), .OutPC(OutPC),
    .OutReady(OutReady), .Count(Count)
  );

  // instruction memory returns a word derived from the requested address
  assign InstrIn = InstrAddr ^ XOR_KEY;

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic checkOutput();
    logic          exp_read;
    logic          exp_valid;
    logic [CW-1:0] exp_count;
    exp_read  = !Reset && !Redirect && (model_q.size() < DEPTH);
    exp_valid = (model_q.size() != 0);
    exp_count = CW'(model_q.size());

    checks++;
    assert (InstrRead === exp_read) else begin
      failures++;
      $error("[TB] FAIL InstrRead cycle=%0d observed=%b expected=%b", cycle, InstrRead, exp_read);
    end
    checks++;
    assert (Count === exp_count) else begin
      failures++;
      $error("[TB] FAIL Count cycle=%0d observed=%0d expected=%0d", cycle, Count, exp_count);
    end
    checks++;
    assert (OutValid === exp_valid) else begin
      failures++;
      $error("[TB] FAIL OutValid cycle=%0d observed=%b expected=%b", cycle, OutValid, exp_valid);
    end
    if (exp_read) begin
      checks++;
      assert (InstrAddr === model_pc) else begin
        failures++;
        $error("[TB] FAIL InstrAddr cycle=%0d observed=%h expected=%h", cycle, InstrAddr, model_pc);
      end
    end
    if (exp_valid) begin
      checks++;
      assert (OutPC === model_q[0]) else begin
        failures++;
        $error("[TB] FAIL OutPC cycle=%0d observed=%h expected=%h", cycle, OutPC, model_q[0]);
      end
      checks++;
      assert (OutInstr === (model_q[0] ^ XOR_KEY)) else begin
        failures++;
        $error("[TB] FAIL OutInstr cycle=%0d observed=%h expected=%h", cycle, OutInstr,
               model_q[0] ^ XOR_KEY);
      end
    end
  endtask

  // One cycle: drive inputs after the falling edge, check, then advance the model at the rising edge.
  task automatic applyStimulus(input logic rst, input logic wq, input logic rdy,
                               input logic rdr, input logic [WS-1:0] rpc, input logic do_check);
    logic will_read;
    logic will_push;
    logic will_pop;
    @(negedge Clock);
    Reset        = rst;
    InstrWaitreq = wq;
    OutReady     = rdy;
    Redirect     = rdr;
    RedirectPC   = rpc;
    #1;
    if (do_check) checkOutput();
    will_read = !rst && !rdr && (model_q.size() < DEPTH);
    will_push = will_read && !wq;
    will_pop  = (model_q.size() != 0) && rdy && !rdr;
    @(posedge Clock);
    cycle++;
    if (rst) begin
      model_q.delete();
      model_pc = RESET_PC;
    end else if (rdr) begin
      model_q.delete();
      model_pc = rpc;
    end else begin
      if (will_pop) void'(model_q.pop_front());
      if (will_push) begin
        model_q.push_back(model_pc);
        model_pc = model_pc + 16'd1;
      end
    end
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    cycle        = 0;
    model_pc     = RESET_PC;
    Reset        = 1'b1;
    InstrWaitreq = 1'b0;
    OutReady     = 1'b0;
    Redirect     = 1'b0;
    RedirectPC   = '0;

    // reset: first cycle establishes state, second is checked
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 16'h0, 1'b1);

    // streaming at one instruction per cycle from RESET_PC
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b1);

    // back-pressure fills the queue, then drains in order
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b1);

    // memory wait-request holds the address for three cycles
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b1);

    // build up occupancy, then redirect while Decode is also ready
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 16'h0100, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b1);

    // address wrap at the top of the address space
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 16'hFFFF, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b1);

    // back-to-back redirects: the last target wins
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 16'h0200, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 16'h0300, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b1);

    // reset while full and stalled
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b1);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic          r_rst;
      logic          r_wq;
      logic          r_rdy;
      logic          r_rdr;
      logic [WS-1:0] r_pc;
      r_rst = ($urandom_range(0, 63) == 0);
      r_wq  = ($urandom_range(0, 3) == 0);
      r_rdy = ($urandom_range(0, 2) != 0);
      r_rdr = ($urandom_range(0, 15) == 0);
      r_pc  = WS'($urandom);
      applyStimulus(r_rst, r_wq, r_rdy, r_rdr, r_pc, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
